// File: rtl/mcu_bus_pkg.sv
// Shared types for the 8051 external bus sequencer: FSM states, grant encoding
// and transaction kinds.
package mcu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        STROBE,
        END
    } bus_state_e;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        FETCH,
        READ,
        WRITE
    } bus_kind_e;

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// Requester and pad signals of the external bus controller. Optional port
// ext_wait_n exists only when EXT_BUS_WAIT_EN is defined.
interface ext_bus_ctrl_if;

    // Handshake: each requester raises req (level) with its address, kind and
    // data stable, and keeps them until the one-cycle ack; ack doubles as
    // "rdata valid". Only the ack pulse completes a request.
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [7:0]  f_rdata;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic [7:0]  d_rdata;

    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in;
    logic [7:0]  addr_hi;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
`ifdef EXT_BUS_WAIT_EN
    logic        ext_wait_n;
`endif

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ad_in,
`ifdef EXT_BUS_WAIT_EN
        input  ext_wait_n,
`endif
        output f_ack, f_rdata, d_ack, d_rdata,
        output ad_out, ad_oe, addr_hi, ale, psen_n, rd_n, wr_n
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ad_in,
`ifdef EXT_BUS_WAIT_EN
        output ext_wait_n,
`endif
        input  f_ack, f_rdata, d_ack, d_rdata,
        input  ad_out, ad_oe, addr_hi, ale, psen_n, rd_n, wr_n
    );

endinterface

// File: rtl/bus_phase_timer.sv
// 4-bit loadable down-counter timing the ADDR and STROBE phases; done is high
// while the count is zero (the last cycle of the phase).
module bus_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd0);

endmodule

// File: rtl/ext_bus_ctrl.sv
// Round-robin arbiter and ALE/PSEN#/RD#/WR# sequencer for the 8051 external bus.
// Define EXT_BUS_WAIT_EN to add the ext_wait_n strobe-extension input.
module ext_bus_ctrl
    import mcu_bus_pkg::*;
#(
    parameter int unsigned ALE_CYCLES    = 2,
    parameter int unsigned STROBE_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ext_bus_ctrl_if.master bus,
    output bus_state_e     dbg_state
);

    bus_state_e state;
    bus_kind_e  kind;
    logic       last_grant;
    logic [7:0] wdata_q;

    logic        any_req;
    logic        grant_c;
    logic [15:0] sel_addr;
    bus_kind_e   sel_kind;
    logic        timer_load;
    logic [3:0]  timer_val;
    logic        timer_done;
    logic        strobe_release;

    assign any_req = bus.f_req | bus.d_req;

    always_comb begin
        grant_c = bus.f_req ? GNT_FETCH : GNT_DATA;
        if (bus.f_req && bus.d_req) begin
            grant_c = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end
        sel_addr = (grant_c == GNT_FETCH) ? bus.f_addr : bus.d_addr;
        sel_kind = (grant_c == GNT_FETCH) ? FETCH : (bus.d_we ? WRITE : READ);
    end

`ifdef EXT_BUS_WAIT_EN
    assign strobe_release = bus.ext_wait_n;
`else
    assign strobe_release = 1'b1;
`endif

    // One timer serves both timed phases: loaded on the grant edge for ADDR and
    // on the LATCH->STROBE edge for STROBE.
    assign timer_load = ((state == IDLE) && any_req) || (state == LATCH);
    assign timer_val  = (state == LATCH) ? 4'(STROBE_CYCLES - 1) : 4'(ALE_CYCLES - 1);

    bus_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            kind        <= FETCH;
            last_grant  <= GNT_DATA;
            wdata_q     <= 8'h00;
            bus.ale     <= 1'b0;
            bus.psen_n  <= 1'b1;
            bus.rd_n    <= 1'b1;
            bus.wr_n    <= 1'b1;
            bus.ad_oe   <= 1'b0;
            bus.ad_out  <= 8'h00;
            bus.addr_hi <= 8'h00;
            bus.f_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.f_rdata <= 8'h00;
            bus.d_rdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant  <= grant_c;
                        kind        <= sel_kind;
                        wdata_q     <= bus.d_wdata;
                        bus.ale     <= 1'b1;
                        bus.ad_oe   <= 1'b1;
                        bus.ad_out  <= sel_addr[7:0];
                        bus.addr_hi <= sel_addr[15:8];
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (timer_done) begin
                        bus.ale <= 1'b0;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    bus.psen_n <= (kind != FETCH);
                    bus.rd_n   <= (kind != READ);
                    bus.wr_n   <= (kind != WRITE);
                    bus.ad_oe  <= (kind == WRITE);
                    bus.ad_out <= (kind == WRITE) ? wdata_q : 8'h00;
                    state      <= STROBE;
                end
                STROBE: begin
                    // Read data is taken on the edge that closes the final strobe cycle.
                    if (timer_done && strobe_release) begin
                        bus.psen_n <= 1'b1;
                        bus.rd_n   <= 1'b1;
                        bus.wr_n   <= 1'b1;
                        case (kind)
                            FETCH: begin
                                bus.f_rdata <= bus.ad_in;
                                bus.f_ack   <= 1'b1;
                            end
                            READ: begin
                                bus.d_rdata <= bus.ad_in;
                                bus.d_ack   <= 1'b1;
                            end
                            default: bus.d_ack <= 1'b1;
                        endcase
                        state <= END;
                    end
                end
                END: begin
                    bus.f_ack  <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.ad_oe  <= 1'b0;
                    bus.ad_out <= 8'h00;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Sequencer and arbiter for the 8051 core's external multiplexed address/data bus. It shares one bus between two requesters, instruction fetch and MOVX data access, and generates ALE, PSEN#, RD# and WR# with programmable phase lengths. It replaces ad-hoc strobe generation in the CPU top level; tristate resolution of the AD bus stays at the top level.

## Interface
- ALE_CYCLES, 2: cycles ALE is high per transaction (1..15)
- STROBE_CYCLES, 3: cycles PSEN#/RD#/WR# are low per transaction (1..15)
- clk  in  1  system clock (12 MHz oscillator)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- f_req  in  1  fetch request, level, held until f_ack
- f_addr  in  16  fetch address, stable while f_req
- f_ack  out  1  one-cycle pulse, fetch complete; f_rdata valid in the same cycle
- f_rdata  out  8  fetched byte, held until the next fetch completes
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  16  data address
- d_wdata  in  8  write byte
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  8  read byte, held until the next data read completes
- ad_out  out  8  low address / write data to the AD pads
- ad_oe  out  1  AD pad output enable
- ad_in  in  8  AD pad input
- addr_hi  out  8  high address byte
- ale  out  1  address latch enable, active high
- psen_n, rd_n, wr_n  out  1 each  strobes, active low

## Operation
- States: IDLE, ADDR, LATCH, STROBE, END.
- IDLE: sample f_req and d_req. Grant the only pending one. If both are pending, grant the one not granted last (round-robin `last_grant`; reset value = data, so fetch wins first). No request: stay in IDLE.
- On grant, the selected address, kind and write data are registered; later changes on requester inputs are ignored.
- ADDR, ALE_CYCLES cycles: ale=1, ad_oe=1, ad_out=addr[7:0], addr_hi=addr[15:8].
- LATCH, 1 cycle: ale=0, address still driven (hold).
- STROBE, STROBE_CYCLES cycles:
  - fetch: psen_n=0, ad_oe=0
  - read: rd_n=0, ad_oe=0
  - write: wr_n=0, ad_oe=1, ad_out=wdata
  - Reads capture ad_in at the clock edge that ends the last strobe cycle.
- END, 1 cycle: all strobes high; a write keeps driving wdata (hold). The granted ack pulses. Next state is IDLE.
- addr_hi holds its last value between transactions. ad_out and ad_oe return to 0 in IDLE.
- The requester drops req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Dropping req before ack is illegal. The transaction completes and the ack still pulses.
- Phase counter is 4 bits and loads N-1 on phase entry. Only the 1..15 range is supported.

## Timing
- Reset values: ale=0, psen_n=rd_n=wr_n=1, ad_oe=0, ad_out=0, addr_hi=0, f_ack=d_ack=0, f_rdata=d_rdata=0, state=IDLE.
- Asserting rst_n mid-transaction forces every strobe inactive and ad_oe=0 at once, with no clock needed. The in-flight transaction is lost and no ack is generated.
- Latency: with req first seen high in IDLE at cycle 0, ack is high in cycle ALE_CYCLES+STROBE_CYCLES+2 (cycle 7 by default).
- Bus occupancy is ALE_CYCLES+STROBE_CYCLES+3 cycles including IDLE. There is at least one IDLE cycle between transactions.
- All outputs are registered. No strobe overlaps ale. ale and strobes are never asserted in the same cycle.

## Configuration
- EXT_BUS_WAIT_EN defined: an extra input port `ext_wait_n` (1 bit, active low) is present. While it is low during the last STROBE cycle, STROBE is extended one cycle at a time. ad_in is sampled at the first edge where ext_wait_n=1 in the last strobe cycle.
- EXT_BUS_WAIT_EN undefined: the port is absent and strobe length is exactly STROBE_CYCLES.

## Structure
- Shared package `mcu_bus_pkg` holds:
  - the state enum (IDLE/ADDR/LATCH/STROBE/END)
  - grant encoding (GNT_FETCH=0, GNT_DATA=1)
  - transaction-kind constants (FETCH/READ/WRITE)
- One sub-module, `bus_phase_timer`: a 4-bit loadable down-counter with a `done` flag. It is shared by the ADDR and STROBE phases.

## Test plan
- Reset mid-STROBE of a write: pull rst_n low, then check wr_n=1, ad_oe=0, ale=0 asynchronously, with no d_ack.
- Single fetch at 0x1234, defaults, ad_in=0xA5 during strobe: ale high for 2 cycles with ad_out=0x34 and addr_hi=0x12; psen_n low for 3 cycles; f_ack in cycle 7; f_rdata=0xA5.
- Data write at 0x00FF with wdata 0x3C: wr_n low for 3 cycles, ad_out=0x3C and ad_oe=1 through END, rd_n and psen_n stay 1, d_ack pulses once.
- f_req and d_req both held continuously from reset: grants alternate fetch, data, fetch, data, one IDLE cycle between each; no starvation over 20 transactions.
- Requester changes d_addr and d_wdata after grant: bus still shows the originally registered values.
- With EXT_BUS_WAIT_EN and ext_wait_n low for 4 cycles on a read: rd_n is low for 7 cycles, data is sampled after release, and d_ack arrives 4 cycles later than nominal.
